// File: rtl/vga_bounce_box_if.sv
// vga_bounce_box_if
// Raster-side bundle between the timing driver, the bounce-box pixel
// source and the rgb stage.
//
// Signals:
//   x_in, y_in   raster column/line, meaningful while de_in = 1
//   de_in        active-video flag
//   hsync_in     horizontal sync from the timing driver (positive polarity)
//   vsync_in     vertical sync from the timing driver (positive polarity)
//   en           registered RRRGGGBB colour word towards rgb
//   hsync, vsync sync signals re-aligned with en (1 cycle delay)
//
// Handshake: this is a free-running stream with no valid/ready pair. Every
// clock carries one raster position; de_in qualifies it as visible. The
// consumer can never stall the producer, and en/hsync/vsync follow the
// inputs with a fixed 1-cycle latency.
//
// Modports:
//   master  timing-driver side (drives the raster, observes the pixel)
//   slave   pixel-source side (consumes the raster, drives the pixel)

interface vga_bounce_box_if;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  en;
    logic        hsync;
    logic        vsync;

    modport master (
        output x_in, y_in, de_in, hsync_in, vsync_in,
        input  en, hsync, vsync
    );

    modport slave (
        input  x_in, y_in, de_in, hsync_in, vsync_in,
        output en, hsync, vsync
    );
endinterface

// File: rtl/vga_bounce_box.sv
// vga_bounce_box
// Pixel source for the 800x600@60 Hz path. It draws a solid rectangle on a
// background colour. The rectangle moves once per frame, on the rising edge
// of vsync. It bounces off the screen edges and takes the next palette
// colour on every bounce. The sync signals are delayed by one register so
// they stay aligned with the registered colour word.
//
// Ports:
//   clk          40 MHz pixel clock
//   rst_n        asynchronous, active-low reset
//   run          1 = box advances each frame, 0 = motion/colour frozen
//   vga          raster in / pixel out bundle (slave modport)
//   bounce_cnt   number of bounce events, wraps 255 -> 0
//   dbg_box_x    current top-left column of the box
//   dbg_box_y    current top-left line of the box
//   dbg_dir_x    horizontal direction (0 = right, 1 = left)
//   dbg_dir_y    vertical direction (0 = down, 1 = up)
//   dbg_col_idx  current palette index

module vga_bounce_box #(
    parameter int          H_ACTIVE = 800,
    parameter int          V_ACTIVE = 600,
    parameter int          BOX_W    = 64,
    parameter int          BOX_H    = 48,
    parameter int          STEP_X   = 2,
    parameter int          STEP_Y   = 1,
    parameter logic [7:0]  BG_COLOR = 8'h03
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    vga_bounce_box_if.slave      vga,
    output logic [7:0]           bounce_cnt,
    output logic [10:0]          dbg_box_x,
    output logic [9:0]           dbg_box_y,
    output logic                 dbg_dir_x,
    output logic                 dbg_dir_y,
    output logic [1:0]           dbg_col_idx
);

    // All geometry is evaluated in 12 bits so box + size + step never wraps.
    localparam logic [11:0] HA12 = 12'(H_ACTIVE);
    localparam logic [11:0] VA12 = 12'(V_ACTIVE);
    localparam logic [11:0] BW12 = 12'(BOX_W);
    localparam logic [11:0] BH12 = 12'(BOX_H);
    localparam logic [11:0] SX12 = 12'(STEP_X);
    localparam logic [11:0] SY12 = 12'(STEP_Y);

    logic [10:0] box_x;
    logic [9:0]  box_y;
    logic        dir_x;
    logic        dir_y;
    logic [1:0]  col_idx;
    logic        vs_d;

    logic        frame_tick;
    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic [11:0] nxt_x;
    logic [11:0] nxt_y;
    logic        nxt_dir_x;
    logic        nxt_dir_y;
    logic        bounce_x;
    logic        bounce_y;

    logic [11:0] px_x;
    logic [11:0] px_y;
    logic        in_box;
    logic [7:0]  box_color;
    logic [7:0]  pix_nxt;

    assign x_ext      = {1'b0, box_x};
    assign y_ext      = {2'b00, box_y};
    assign frame_tick = vga.vsync_in & ~vs_d;

    // Horizontal motion. Landing exactly on an edge is not a bounce; the
    // bounce happens on the following tick, which clamps the box in place.
    always_comb begin
        nxt_x     = x_ext;
        nxt_dir_x = dir_x;
        bounce_x  = 1'b0;
        if (!dir_x) begin
            if (x_ext + BW12 + SX12 > HA12) begin
                nxt_x     = HA12 - BW12;
                nxt_dir_x = 1'b1;
                bounce_x  = 1'b1;
            end else begin
                nxt_x = x_ext + SX12;
            end
        end else begin
            if (x_ext < SX12) begin
                nxt_x     = 12'd0;
                nxt_dir_x = 1'b0;
                bounce_x  = 1'b1;
            end else begin
                nxt_x = x_ext - SX12;
            end
        end
    end

    // Vertical motion, same rule set as the horizontal axis.
    always_comb begin
        nxt_y     = y_ext;
        nxt_dir_y = dir_y;
        bounce_y  = 1'b0;
        if (!dir_y) begin
            if (y_ext + BH12 + SY12 > VA12) begin
                nxt_y     = VA12 - BH12;
                nxt_dir_y = 1'b1;
                bounce_y  = 1'b1;
            end else begin
                nxt_y = y_ext + SY12;
            end
        end else begin
            if (y_ext < SY12) begin
                nxt_y     = 12'd0;
                nxt_dir_y = 1'b0;
                bounce_y  = 1'b1;
            end else begin
                nxt_y = y_ext - SY12;
            end
        end
    end

    // Motion state only moves on a frame tick, which falls inside vertical
    // blanking, so every visible line of a frame sees the same box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x      <= '0;
            box_y      <= '0;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            col_idx    <= '0;
            bounce_cnt <= '0;
            vs_d       <= 1'b0;
        end else begin
            vs_d <= vga.vsync_in;
            if (frame_tick && run) begin
                box_x <= nxt_x[10:0];
                box_y <= nxt_y[9:0];
                dir_x <= nxt_dir_x;
                dir_y <= nxt_dir_y;
                // A corner hit bounces both axes but is one event.
                if (bounce_x || bounce_y) begin
                    col_idx    <= col_idx + 2'd1;
                    bounce_cnt <= bounce_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        box_color = 8'hE0;
        case (col_idx)
            2'd0: box_color = 8'hE0;
            2'd1: box_color = 8'h1C;
            2'd2: box_color = 8'hFC;
            2'd3: box_color = 8'hE3;
            default: box_color = 8'hE0;
        endcase
    end

    assign px_x   = {1'b0, vga.x_in};
    assign px_y   = {2'b00, vga.y_in};
    assign in_box = (px_x >= x_ext) && (px_x < x_ext + BW12) &&
                    (px_y >= y_ext) && (px_y < y_ext + BH12);

    always_comb begin
        pix_nxt = 8'h00;
        if (vga.de_in) begin
            pix_nxt = in_box ? box_color : BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.en    <= 8'h00;
            vga.hsync <= 1'b0;
            vga.vsync <= 1'b0;
        end else begin
            vga.en    <= pix_nxt;
            vga.hsync <= vga.hsync_in;
            vga.vsync <= vga.vsync_in;
        end
    end

    assign dbg_box_x   = box_x;
    assign dbg_box_y   = box_y;
    assign dbg_dir_x   = dir_x;
    assign dbg_dir_y   = dir_y;
    assign dbg_col_idx = col_idx;

endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box
// Self-checking bench for vga_bounce_box. The main instance uses the default
// geometry. A second instance uses a near-full-screen box so that both axes
// bounce on the same frame tick.

module tb_vga_bounce_box;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int SX = 2;
    localparam int SY = 1;

    logic clk;
    logic rst_n;
    logic run;

    vga_bounce_box_if vif();
    vga_bounce_box_if cif();

    logic [7:0]  bounce_cnt, c_bounce_cnt;
    logic [10:0] dbg_box_x, c_box_x;
    logic [9:0]  dbg_box_y, c_box_y;
    logic        dbg_dir_x, c_dir_x;
    logic        dbg_dir_y, c_dir_y;
    logic [1:0]  dbg_col_idx, c_col_idx;

    vga_bounce_box u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .vga         (vif),
        .bounce_cnt  (bounce_cnt),
        .dbg_box_x   (dbg_box_x),
        .dbg_box_y   (dbg_box_y),
        .dbg_dir_x   (dbg_dir_x),
        .dbg_dir_y   (dbg_dir_y),
        .dbg_col_idx (dbg_col_idx)
    );

    vga_bounce_box #(
        .BOX_W (796), .BOX_H (596), .STEP_X (2), .STEP_Y (2)
    ) u_corner (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .vga         (cif),
        .bounce_cnt  (c_bounce_cnt),
        .dbg_box_x   (c_box_x),
        .dbg_box_y   (c_box_y),
        .dbg_dir_x   (c_dir_x),
        .dbg_dir_y   (c_dir_y),
        .dbg_col_idx (c_col_idx)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_x, m_y, m_left, m_up, m_col, m_cnt;
    logic [7:0] palette [4] = '{8'hE0, 8'h1C, 8'hFC, 8'hE3};

    function automatic logic [7:0] exp_en(input int x, input int y, input bit de);
        if (!de) return 8'h00;
        if (x >= m_x && x < m_x + W && y >= m_y && y < m_y + H) return palette[m_col];
        return 8'h03;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_left = 0; m_up = 0; m_col = 0; m_cnt = 0;
    endtask

    // One frame: move by the step or, if the step would leave the screen,
    // pin to the edge and turn round. Any turn counts as one bounce.
    task automatic model_tick();
        bit hit;
        hit = 0;
        if (!run) return;
        if (!m_left) begin
            if (m_x + W + SX > 800) begin m_x = 800 - W; m_left = 1; hit = 1; end
            else m_x = m_x + SX;
        end else begin
            if (m_x < SX) begin m_x = 0; m_left = 0; hit = 1; end
            else m_x = m_x - SX;
        end
        if (!m_up) begin
            if (m_y + H + SY > 600) begin m_y = 600 - H; m_up = 1; hit = 1; end
            else m_y = m_y + SY;
        end else begin
            if (m_y < SY) begin m_y = 0; m_up = 0; hit = 1; end
            else m_y = m_y - SY;
        end
        if (hit) begin
            m_col = (m_col + 1) % 4;
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".box_x"}, 32'(dbg_box_x), 32'(m_x));
        check({tag, ".box_y"}, 32'(dbg_box_y), 32'(m_y));
        check({tag, ".col"},   32'(dbg_col_idx), 32'(m_col));
        check({tag, ".cnt"},   32'(bounce_cnt), 32'(m_cnt));
    endtask

    // ---------------- drivers ----------------
    task automatic pix(input int x, input int y, input bit de, input bit hs, input string tag);
        @(negedge clk);
        vif.x_in     = 11'(x);
        vif.y_in     = 10'(y);
        vif.de_in    = de;
        vif.hsync_in = hs;
        vif.vsync_in = 1'b0;
        @(posedge clk); #1;
        check({tag, ".en"}, 32'(vif.en), 32'(exp_en(x, y, de)));
        check({tag, ".hsync"}, 32'(vif.hsync), 32'(hs));
    endtask

    // Two-cycle vsync pulse: one rising edge, so one frame tick.
    task automatic tick(input bit do_check);
        @(negedge clk);
        vif.de_in    = 1'b0;
        vif.vsync_in = 1'b1;
        @(posedge clk); #1;
        model_tick();
        if (do_check) begin
            check("tick.vsync_hi", 32'(vif.vsync), 32'd1);
            check_state("tick");
        end
        @(negedge clk);
        vif.vsync_in = 1'b0;
        @(posedge clk); #1;
        if (do_check) check("tick.vsync_lo", 32'(vif.vsync), 32'd0);
    endtask

    task automatic rand_pixels(input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 599);
            end else begin
                x = m_x - 2 + $urandom_range(0, W + 3);
                y = m_y - 2 + $urandom_range(0, H + 3);
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end
            pix(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, "rand");
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        vif.x_in = '0; vif.y_in = '0; vif.de_in = 1'b0;
        vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
        cif.x_in = '0; cif.y_in = '0; cif.de_in = 1'b0;
        cif.hsync_in = 1'b0; cif.vsync_in = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst.en", 32'(vif.en), 32'h00);
        check("rst.hsync", 32'(vif.hsync), 32'd0);
        check("rst.vsync", 32'(vif.vsync), 32'd0);
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First frame, box at (0,0).
        pix(0, 0, 1, 1, "f0.p00");
        check("f0.p00.const", 32'(vif.en), 32'hE0);
        pix(63, 47, 1, 0, "f0.p6347");
        check("f0.p6347.const", 32'(vif.en), 32'hE0);
        pix(64, 0, 1, 1, "f0.p640");
        check("f0.p640.const", 32'(vif.en), 32'h03);
        pix(0, 48, 1, 0, "f0.p048");
        check("f0.p048.const", 32'(vif.en), 32'h03);
        pix(10, 10, 0, 1, "f0.de0");
        check("f0.de0.const", 32'(vif.en), 32'h00);

        // One tick -> (2,1).
        tick(1);
        check("t1.x", 32'(dbg_box_x), 32'd2);
        check("t1.y", 32'(dbg_box_y), 32'd1);
        pix(1, 0, 1, 0, "t1.p10");
        check("t1.p10.const", 32'(vif.en), 32'h03);
        pix(2, 1, 1, 0, "t1.p21");
        check("t1.p21.const", 32'(vif.en), 32'hE0);

        // Up to tick 368: right edge reached exactly, no bounce yet.
        for (int i = 2; i <= 368; i++) tick(0);
        check_state("t368");
        check("t368.x", 32'(dbg_box_x), 32'd736);
        check("t368.cnt", 32'(bounce_cnt), 32'd0);
        pix(799, m_y, 1, 1, "t368.redge");

        tick(1);
        check("t369.x", 32'(dbg_box_x), 32'd736);
        check("t369.dir_x", 32'(dbg_dir_x), 32'd1);
        check("t369.col", 32'(dbg_col_idx), 32'd1);
        check("t369.cnt", 32'(bounce_cnt), 32'd1);
        pix(740, m_y + 3, 1, 0, "t369.in");
        check("t369.in.const", 32'(vif.en), 32'h1C);

        tick(1);
        check("t370.x", 32'(dbg_box_x), 32'd734);

        // Randomised frames with occasional run=0.
        for (int i = 0; i < 40; i++) begin
            run = ($urandom_range(0, 3) != 0);
            tick(1);
            rand_pixels(3);
        end
        run = 1'b1;

        // Frozen motion across 10 ticks.
        begin
            int sx, sy, sc, sn;
            sx = m_x; sy = m_y; sc = m_col; sn = m_cnt;
            run = 1'b0;
            for (int i = 0; i < 10; i++) tick(0);
            check("frz.x", 32'(dbg_box_x), 32'(sx));
            check("frz.y", 32'(dbg_box_y), 32'(sy));
            check("frz.col", 32'(dbg_col_idx), 32'(sc));
            check("frz.cnt", 32'(bounce_cnt), 32'(sn));
            rand_pixels(4);
            run = 1'b1;
        end

        // vsync held high for 1000 cycles: exactly one update.
        @(negedge clk);
        vif.de_in    = 1'b0;
        vif.vsync_in = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        model_tick();
        check_state("hold");
        @(negedge clk);
        vif.vsync_in = 1'b0;
        rand_pixels(4);

        // Mid-line reset: outputs clear without a clock edge.
        pix(m_x + 1, m_y + 1, 1, 1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.en", 32'(vif.en), 32'h00);
        check("mrst.hsync", 32'(vif.hsync), 32'd0);
        check("mrst.vsync", 32'(vif.vsync), 32'd0);
        check("mrst.cnt", 32'(bounce_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pix(0, 0, 1, 0, "post_rst");
        check("post_rst.const", 32'(vif.en), 32'hE0);

        // vsync already high at reset release counts as a tick.
        @(negedge clk);
        rst_n = 1'b0;
        vif.vsync_in = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_tick();
        check_state("vs_rel");
        @(negedge clk);
        vif.vsync_in = 1'b0;

        // Corner hit on the large-box instance: tick 3 bounces both axes once.
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            cif.vsync_in = 1'b1;
            @(negedge clk);
            cif.vsync_in = 1'b0;
            if (t == 2) begin
                check("corner.t2.x", 32'(c_box_x), 32'd4);
                check("corner.t2.cnt", 32'(c_bounce_cnt), 32'd0);
            end
        end
        #1;
        check("corner.cnt", 32'(c_bounce_cnt), 32'd1);
        check("corner.dir_x", 32'(c_dir_x), 32'd1);
        check("corner.dir_y", 32'(c_dir_y), 32'd1);
        check("corner.col", 32'(c_col_idx), 32'd1);
        check("corner.x", 32'(c_box_x), 32'd4);
        check("corner.y", 32'(c_box_y), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_bounce_box.md
# vga_bounce_box

Pixel-source stage for the 800x600@60 Hz VGA path, clocked from the 40 MHz PLL output. Consumes the raster position and sync signals produced by the timing driver and generates the 8-bit colour enable word `en[7:0]` (RRRGGGBB) consumed by the `rgb` stage. Renders a solid rectangle on a background. The rectangle moves once per frame and bounces off the screen edges, changing colour on every bounce. Sync signals are delayed through the block so they stay aligned with `en`.

## Interface
- `H_ACTIVE`, 800: visible pixels per line.
- `V_ACTIVE`, 600: visible lines per frame.
- `BOX_W`, 64: box width in pixels; range 1..H_ACTIVE.
- `BOX_H`, 48: box height in lines; range 1..V_ACTIVE.
- `STEP_X`, 2: horizontal pixels moved per frame; must be at least 1.
- `STEP_Y`, 1: vertical lines moved per frame; must be at least 1.
- `BG_COLOR`, 8'h03: colour of active pixels outside the box.
- `clk`  in  1  40 MHz pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  1 = box advances each frame; 0 = position, direction and colour are frozen.
- `x_in`  in  11  current pixel column; valid when `de_in`=1.
- `y_in`  in  10  current line; valid when `de_in`=1.
- `de_in`  in  1  active-video flag.
- `hsync_in`  in  1  horizontal sync, positive polarity.
- `vsync_in`  in  1  vertical sync, positive polarity.
- `en`  out  8  pixel colour to `rgb`; registered.
- `hsync`  out  1  `hsync_in` delayed by 1 cycle.
- `vsync`  out  1  `vsync_in` delayed by 1 cycle.
- `bounce_cnt`  out  8  number of bounce events; wraps from 255 to 0.

## Operation
- State registers:
  - `box_x` (11 bits) and `box_y` (10 bits) hold the top-left corner of the box.
  - `dir_x` (0 = right, 1 = left) and `dir_y` (0 = down, 1 = up).
  - `col_idx` (2 bits) indexes the palette: {8'hE0, 8'h1C, 8'hFC, 8'hE3}.
  - `vs_d` holds the previous `vsync_in` for edge detection.
- Reset state: `box_x`=0, `box_y`=0, `dir_x`=0, `dir_y`=0, `col_idx`=0, `bounce_cnt`=0, `en`=0, `hsync`=0, `vsync`=0, `vs_d`=0.
- Frame tick = `vsync_in` & ~`vs_d`, i.e. a rising edge, once per frame inside vertical blanking. Position is updated only on a frame tick while `run`=1, so there is no tearing.
- X update, computed in 12-bit arithmetic (Y update is identical using `box_y`, `STEP_Y`, `BOX_H`, `V_ACTIVE`):
  - Moving right: if `box_x`+`BOX_W`+`STEP_X` > `H_ACTIVE`, then `box_x` := `H_ACTIVE`-`BOX_W` and `dir_x` := 1 (bounce). Otherwise `box_x` += `STEP_X`.
  - Moving left: if `box_x` < `STEP_X`, then `box_x` := 0 and `dir_x` := 0 (bounce). Otherwise `box_x` -= `STEP_X`.
  - Reaching the edge exactly is not a bounce. The bounce happens on the following tick, with the box clamped in place for that frame.
- Bounce event = X bounce OR Y bounce on the same tick. A corner hit counts once: `col_idx`+1 and `bounce_cnt`+1, both wrapping.
- Pixel path, one registered stage:
  - `de_in`=0 → `en`=8'h00.
  - Otherwise, if `box_x` ≤ `x_in` < `box_x`+`BOX_W` and `box_y` ≤ `y_in` < `box_y`+`BOX_H` → `en` = palette[`col_idx`].
  - Otherwise → `en`=`BG_COLOR`.
- `run`=0: the frame tick is ignored, but rendering and sync delay continue unchanged.
- Inputs outside the active area while `de_in`=1 are not checked; the comparison is purely arithmetic.

## Timing
- Latency is 1 cycle from `x_in`/`y_in`/`de_in`/`hsync_in`/`vsync_in` to `en`/`hsync`/`vsync`. All outputs are registered on the `clk` rising edge.
- Position, direction, colour and count update in the same cycle that the frame tick is asserted, and are visible in the cycle after it.
- The box position used for rendering is constant across all active lines of a frame.
- `rst_n` low at any time, including mid-line: all registers take their reset values immediately, without waiting for a clock. The first frame tick after release moves the box from (0,0).
- `vsync_in` held high for many cycles produces exactly one tick.
- If `vsync_in` is already high when reset is released, that counts as a tick, because `vs_d` resets to 0.

## Test plan
- Reset, then first frame with default parameters:
  - pixel (0,0) → `en`=8'hE0; (63,47) → 8'hE0; (64,0) → 8'h03; (0,48) → 8'h03.
  - `de_in`=0 → 8'h00.
  - `hsync`/`vsync` equal their inputs delayed by 1 cycle.
- One `vsync_in` rising edge with `run`=1 → box at (2,1); pixel (1,0) → 8'h03; pixel (2,1) → 8'hE0.
- 368 ticks → `box_x`=736, `bounce_cnt`=0. Tick 369 → `box_x`=736, `dir_x`=1, `col_idx`=1, `en` inside box = 8'h1C, `bounce_cnt`=1. Tick 370 → `box_x`=734.
- Corner hit, with `BOX_W`=796, `BOX_H`=596, `STEP_X`=`STEP_Y`=2: tick 3 bounces X and Y simultaneously → `bounce_cnt`=1 (not 2), `dir_x`=`dir_y`=1, `col_idx`=1.
- `run`=0 across 10 frame ticks → position, `col_idx` and `bounce_cnt` unchanged. Holding `vsync_in` high for 1000 cycles with `run`=1 → exactly one update.
- Assert `rst_n`=0 mid-line after 400 ticks → `en`, `hsync`, `vsync` and `bounce_cnt` go to 0 before the next clock edge. After release, the box renders at (0,0) in 8'hE0.
